// File: rtl/aes_pkg.sv
// Shared AES row-serial datapath types and constants.
// Row geometry and per-row rotation amounts for the (Inv)ShiftRows stage.
package aes_pkg;

  localparam int ROW_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_ROWS = 4;
  localparam int IDX_W    = $clog2(NUM_ROWS);

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [IDX_W-1:0] row_idx_t;

  typedef struct packed {
    row_t r0;
    row_t r1;
    row_t r2;
    row_t r3;
  } aes_state_t;

  // Row r rotates by r bytes: 0, 8, 16, 24 bits.
  function automatic int rot_amt(input int row);
    return row * BYTE_W;
  endfunction

endpackage

// File: rtl/inv_shift_rows_seq_row_rotate.sv
// Combinational byte rotation of one state row.
// RIGHT=1 rotates towards the LSB (decrypt), RIGHT=0 towards the MSB.
module row_rotate
  import aes_pkg::*;
#(
  parameter int AMT   = 8,
  parameter bit RIGHT = 1'b1
) (
  input  logic [ROW_W-1:0] row_in,
  output logic [ROW_W-1:0] row_out
);

  // A left rotate by N equals a right rotate by ROW_W-N.
  localparam int SH = RIGHT ? AMT : (ROW_W - AMT);

  logic [2*ROW_W-1:0] dbl;

  assign dbl     = {row_in, row_in};
  assign row_out = ROW_W'(dbl >> SH);

endmodule

// File: rtl/inv_shift_rows_seq.sv
// Row-serial (Inv)ShiftRows stage: collects four rows, un-rotates them
// and holds the full state on a valid/ready output register.
module inv_shift_rows_seq
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [ROW_W-1:0] row_in,
  input  logic             row_valid,
  output logic             row_ready,
  output logic [ROW_W-1:0] state0_out,
  output logic [ROW_W-1:0] state1_out,
  output logic [ROW_W-1:0] state2_out,
  output logic [ROW_W-1:0] state3_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam row_idx_t LAST = row_idx_t'(NUM_ROWS - 1);
  localparam row_idx_t ONE  = row_idx_t'(1);

  row_idx_t   row_cnt;
  row_idx_t   row_cnt_nxt;
  row_t       slot [NUM_ROWS-1];
  row_t       raw  [NUM_ROWS];
  row_t       rot  [NUM_ROWS];
  aes_state_t st_nxt;

  logic last_row;
  logic in_fire;
  logic load;
  logic out_fire;

  assign last_row = (row_cnt == LAST);
  // Only the final row can stall, and only behind a held output.
  assign row_ready = !last_row || !out_valid || out_ready;
  assign in_fire   = row_valid && row_ready && !flush;
  assign load      = in_fire && last_row;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (row_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
    end else begin
      row_cnt <= row_cnt_nxt;
    end
  end

  always_comb begin
    row_cnt_nxt = row_cnt;
    unique case (1'b1)
      flush:   row_cnt_nxt = '0;
      in_fire: row_cnt_nxt = row_cnt + ONE;
      default: row_cnt_nxt = row_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROWS - 1; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ROWS - 1; i++) begin
        if (in_fire && row_cnt == row_idx_t'(i)) begin
          slot[i] <= row_in;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROWS - 1; i++) begin
      raw[i] = slot[i];
    end
    raw[NUM_ROWS-1] = row_in;
  end

  assign rot[0] = raw[0];

  for (genvar g = 1; g < NUM_ROWS; g++) begin : g_rot
    row_rotate #(
      .AMT   (rot_amt(g)),
      .RIGHT (INVERSE)
    ) u_rot (
      .row_in  (raw[g]),
      .row_out (rot[g])
    );
  end

  always_comb begin
    st_nxt.r0 = rot[0];
    st_nxt.r1 = rot[1];
    st_nxt.r2 = rot[2];
    st_nxt.r3 = rot[3];
  end

  // A load in the same cycle as an output beat keeps out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state0_out <= '0;
      state1_out <= '0;
      state2_out <= '0;
      state3_out <= '0;
      out_valid  <= 1'b0;
    end else if (load) begin
      state0_out <= st_nxt.r0;
      state1_out <= st_nxt.r1;
      state2_out <= st_nxt.r2;
      state3_out <= st_nxt.r3;
      out_valid  <= 1'b1;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
// Bench for inv_shift_rows_seq: byte-level reference model plus
// directed scenarios, random traffic and a forward/inverse round trip.
module tb_inv_shift_rows_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        row_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] row_in = '0;
  logic        row_ready;
  logic [31:0] s0, s1, s2, s3;
  logic        out_valid;
  logic        busy;

  logic        f_valid = 1'b0;
  logic [31:0] f_row = '0;
  logic        f_ready, f_ov, f_busy;
  logic [31:0] f0, f1, f2, f3;
  logic        r_valid = 1'b0;
  logic [31:0] r_row = '0;
  logic        r_ready, r_ov, r_busy;
  logic [31:0] q0, q1, q2, q3;
  logic        no_flush = 1'b0;
  logic        always_rdy = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  inv_shift_rows_seq #(.INVERSE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .state0_out(s0), .state1_out(s1),
    .state2_out(s2), .state3_out(s3),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  inv_shift_rows_seq #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .reset(reset), .flush(no_flush),
    .row_in(f_row), .row_valid(f_valid), .row_ready(f_ready),
    .state0_out(f0), .state1_out(f1),
    .state2_out(f2), .state3_out(f3),
    .out_valid(f_ov), .out_ready(always_rdy), .busy(f_busy)
  );

  inv_shift_rows_seq #(.INVERSE(1'b1)) u_rt (
    .clk(clk), .reset(reset), .flush(no_flush),
    .row_in(r_row), .row_valid(r_valid), .row_ready(r_ready),
    .state0_out(q0), .state1_out(q1),
    .state2_out(q2), .state3_out(q3),
    .out_valid(r_ov), .out_ready(always_rdy), .busy(r_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Output column c takes input column (c - r) mod 4 (inverse)
  // or (c + r) mod 4 (forward).
  function automatic logic [31:0] ref_row(input logic [31:0] r,
                                          input int ri, input bit inv);
    logic [31:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      src = inv ? (c - ri + 4) % 4 : (c + ri) % 4;
      o[31-8*c -: 8] = r[31-8*src -: 8];
    end
    return o;
  endfunction

  logic [31:0] coll[$];
  logic [31:0] m_st[4] = '{default: '0};
  bit          m_v = 1'b0;

  always @(negedge clk) begin
    bit exp_rdy;
    bit loaded;
    if (mon_en) begin
      exp_rdy = !(coll.size() == 3 && m_v && !out_ready);
      loaded = 1'b0;
      chk("row_ready", row_ready, exp_rdy);
      chk("out_valid", out_valid, m_v);
      chk("busy", busy, coll.size() != 0);
      chk("state0", s0, m_st[0]);
      chk("state1", s1, m_st[1]);
      chk("state2", s2, m_st[2]);
      chk("state3", s3, m_st[3]);
      if (reset) begin
        coll.delete();
        m_v = 1'b0;
        for (int i = 0; i < 4; i++) m_st[i] = '0;
      end else begin
        if (flush) begin
          coll.delete();
        end else if (row_valid && exp_rdy) begin
          coll.push_back(row_in);
          if (coll.size() == 4) begin
            for (int i = 0; i < 4; i++) m_st[i] = ref_row(coll[i], i, 1'b1);
            m_v = 1'b1;
            loaded = 1'b1;
            coll.delete();
          end
        end
        if (!loaded && m_v && out_ready) m_v = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input logic [31:0] r, output int waits);
    bit acc;
    row_valid = 1'b1;
    row_in = r;
    waits = 0;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = row_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_state(input string tag, input logic [31:0] r[4]);
    chk({tag, "_v"}, out_valid, 1'b1);
    chk({tag, "_s0"}, s0, ref_row(r[0], 0, 1'b1));
    chk({tag, "_s1"}, s1, ref_row(r[1], 1, 1'b1));
    chk({tag, "_s2"}, s2, ref_row(r[2], 2, 1'b1));
    chk({tag, "_s3"}, s3, ref_row(r[3], 3, 1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int tot;
    logic [31:0] rows[4];
    logic [31:0] orig[4];
    logic [31:0] fw[4];
    logic [31:0] x;

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(1);
    reset = 1'b0;

    // Directed example rows
    out_ready = 1'b1;
    rows = '{32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233};
    for (int i = 0; i < 4; i++) send_row(rows[i], w);
    row_valid = 1'b0;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_s0", s0, 32'h00010203);
    chk("t1_s1", s1, 32'h13101112);
    chk("t1_s2", s2, 32'h22232021);
    chk("t1_s3", s3, 32'h31323330);
    cyc(1);
    chk("t1_drain", out_valid, 1'b0);

    // Back-to-back states, no bubbles
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_row($urandom, w);
      tot += w;
    end
    row_valid = 1'b0;
    chk("t2_waits", tot, 0);
    cyc(2);

    // Held output, second state streamed in behind it
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_row($urandom, w);
    for (int i = 0; i < 3; i++) begin
      rows[i] = $urandom;
      send_row(rows[i], w);
    end
    x = $urandom;
    rows[3] = x;
    row_valid = 1'b1;
    row_in = x;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall", row_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_go", row_ready, 1'b1);
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    chk_state("t3", rows);
    cyc(2);

    // Flush mid-collection
    send_row($urandom, w);
    chk("t4_busy", busy, 1'b1);
    send_row($urandom, w);
    row_in = $urandom;
    row_valid = 1'b1;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    row_valid = 1'b0;
    chk("t4_flushed", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rows[i] = $urandom;
      send_row(rows[i], w);
    end
    row_valid = 1'b0;
    chk_state("t4", rows);
    cyc(2);

    // Reset while stalled with a partial state
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_row($urandom, w);
    for (int i = 0; i < 3; i++) send_row($urandom, w);
    row_valid = 1'b0;
    chk("t5_pre", out_valid, 1'b1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_s0", s0, 32'h0);
    chk("t5_s3", s3, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rows[i] = $urandom;
      send_row(rows[i], w);
    end
    row_valid = 1'b0;
    chk_state("t5", rows);
    cyc(2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      row_valid = ($urandom % 4) != 0;
      row_in = $urandom;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      cyc(1);
    end
    row_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    cyc(3);

    // Forward then inverse round trip
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++) orig[i] = $urandom;
      for (int i = 0; i < 4; i++) begin
        f_valid = 1'b1;
        f_row = orig[i];
        chk("t6_fready", f_ready, 1'b1);
        cyc(1);
      end
      f_valid = 1'b0;
      chk("t6_fvalid", f_ov, 1'b1);
      fw = '{f0, f1, f2, f3};
      for (int i = 0; i < 4; i++) chk("t6_fwd", fw[i], ref_row(orig[i], i, 1'b0));
      for (int i = 0; i < 4; i++) begin
        r_valid = 1'b1;
        r_row = fw[i];
        cyc(1);
      end
      r_valid = 1'b0;
      chk("t6_rvalid", r_ov, 1'b1);
      chk("t6_rt0", q0, orig[0]);
      chk("t6_rt1", q1, orig[1]);
      chk("t6_rt2", q2, orig[2]);
      chk("t6_rt3", q3, orig[3]);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
